// File: rtl/sysid_pkg.sv
// Shared constants for the system-identification register block:
// word addresses, CTRL bit positions and the default version word.
package sysid_pkg;

    typedef enum logic [2:0] {
        ADDR_ID             = 3'd0,
        ADDR_TIMESTAMP      = 3'd1,
        ADDR_VERSION        = 3'd2,
        ADDR_SCRATCH        = 3'd3,
        ADDR_UPTIME_LO      = 3'd4,
        ADDR_UPTIME_HI_SNAP = 3'd5,
        ADDR_CTRL           = 3'd6,
        ADDR_RSVD           = 3'd7
    } reg_addr_e;

    localparam int CTRL_EN_BIT  = 0;
    localparam int CTRL_CLR_BIT = 1;

    localparam logic [31:0] DEFAULT_VERSION = 32'h0001_0000;

endpackage

// File: rtl/sysid_rd_pipe.sv
// Read response path: a capture register loaded by an accepted read, followed
// by DEPTH extra valid/data delay stages. Data only moves alongside its valid.
module sysid_rd_pipe #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              valid_out,
    output logic [DATA_W-1:0] data_out
);

    logic              valid_reg [0:DEPTH];
    logic [DATA_W-1:0] data_reg  [0:DEPTH];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_reg[0] <= 1'b0;
            data_reg[0]  <= '0;
        end else begin
            valid_reg[0] <= valid_in;
            if (valid_in) begin
                data_reg[0] <= data_in;
            end
        end
    end

    // Holding data when no valid moves keeps the final output stable between responses.
    generate
        for (genvar gi = 1; gi <= DEPTH; gi++) begin : g_stage
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    valid_reg[gi] <= 1'b0;
                    data_reg[gi]  <= '0;
                end else begin
                    valid_reg[gi] <= valid_reg[gi-1];
                    if (valid_reg[gi-1]) begin
                        data_reg[gi] <= data_reg[gi-1];
                    end
                end
            end
        end
    endgenerate

    assign valid_out = valid_reg[DEPTH];
    assign data_out  = data_reg[DEPTH];

endmodule

// File: rtl/sysid_regs_mm.sv
// Avalon-MM system-ID slave: read-only build words, scratch register and a
// free-running uptime counter whose high half is snapshotted by each low-word read.
module sysid_regs_mm
    import sysid_pkg::*;
#(
    parameter int unsigned SYSTEM_ID    = 28,
    parameter int unsigned TIMESTAMP    = 1718117590,
    parameter logic [31:0] VERSION      = DEFAULT_VERSION,
    parameter int          DATA_W       = 32,
    parameter int          CNT_W        = 64,
    parameter int          READ_LATENCY = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [2:0]        address,
    input  logic              read,
    input  logic              write,
    input  logic [DATA_W-1:0] writedata,
    output logic [DATA_W-1:0] readdata,
    output logic              readdatavalid
);

    localparam int HI_W = CNT_W - DATA_W;

    localparam logic [DATA_W-1:0] ID_WORD        = DATA_W'(SYSTEM_ID);
    localparam logic [DATA_W-1:0] TIMESTAMP_WORD = DATA_W'(TIMESTAMP);
    localparam logic [DATA_W-1:0] VERSION_WORD   = DATA_W'(VERSION);

    logic [DATA_W-1:0] scratch_reg;
    logic              en_reg;
    logic [CNT_W-1:0]  counter_reg;
    logic [DATA_W-1:0] snap_reg;

    logic              wr_accept;
    logic              scratch_we;
    logic              ctrl_we;
    logic              clr;
    logic              snap_load;
    logic [DATA_W-1:0] hi_ext;
    logic [DATA_W-1:0] rd_mux;

    // A read in the same cycle as a write wins; the write is dropped.
    assign wr_accept  = write && !read;
    assign scratch_we = wr_accept && (address == ADDR_SCRATCH);
    assign ctrl_we    = wr_accept && (address == ADDR_CTRL);
    assign clr        = ctrl_we && writedata[CTRL_CLR_BIT];
    assign snap_load  = read && (address == ADDR_UPTIME_LO);

    always_comb begin
        hi_ext = '0;
        hi_ext[HI_W-1:0] = counter_reg[CNT_W-1:DATA_W];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            scratch_reg <= '0;
            en_reg      <= 1'b1;
            counter_reg <= '0;
            snap_reg    <= '0;
        end else begin
            if (scratch_we) begin
                scratch_reg <= writedata;
            end
            if (ctrl_we) begin
                en_reg <= writedata[CTRL_EN_BIT];
            end
            // CLR overrides counting regardless of EN; a new EN applies from the next edge.
            if (clr) begin
                counter_reg <= '0;
            end else if (en_reg) begin
                counter_reg <= counter_reg + CNT_W'(1);
            end
            if (snap_load) begin
                snap_reg <= hi_ext;
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        case (reg_addr_e'(address))
            ADDR_ID:             rd_mux = ID_WORD;
            ADDR_TIMESTAMP:      rd_mux = TIMESTAMP_WORD;
            ADDR_VERSION:        rd_mux = VERSION_WORD;
            ADDR_SCRATCH:        rd_mux = scratch_reg;
            ADDR_UPTIME_LO:      rd_mux = counter_reg[DATA_W-1:0];
            ADDR_UPTIME_HI_SNAP: rd_mux = snap_reg;
            ADDR_CTRL:           rd_mux[CTRL_EN_BIT] = en_reg;
            default:             rd_mux = '0;
        endcase
    end

    sysid_rd_pipe #(
        .DATA_W (DATA_W),
        .DEPTH  (READ_LATENCY - 1)
    ) u_rd_pipe (
        .clock     (clock),
        .reset_n   (reset_n),
        .valid_in  (read),
        .data_in   (rd_mux),
        .valid_out (readdatavalid),
        .data_out  (readdata)
    );

endmodule

// File: tb/tb_sysid_regs_mm.sv
// Self-checking bench for sysid_regs_mm: a latency-2 instance driven from a
// vector table with a response scoreboard, plus narrow and latency-4 instances.
module tb_sysid_regs_mm;
    import sysid_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    // Latency-2, 32/64-bit instance
    logic        m_rst_n = 1'b0;
    logic        m_read  = 1'b0;
    logic        m_write = 1'b0;
    logic [2:0]  m_addr  = 3'd0;
    logic [31:0] m_wdata = '0;
    logic [31:0] m_rdata;
    logic        m_rdv;

    sysid_regs_mm #(.READ_LATENCY(2)) u_main (
        .clock(clk), .reset_n(m_rst_n), .address(m_addr), .read(m_read),
        .write(m_write), .writedata(m_wdata), .readdata(m_rdata), .readdatavalid(m_rdv)
    );

    // Narrow 8/16-bit instance, latency 1
    logic        s_rst_n = 1'b0;
    logic        s_read  = 1'b0;
    logic        s_write = 1'b0;
    logic [2:0]  s_addr  = 3'd0;
    logic [7:0]  s_wdata = '0;
    logic [7:0]  s_rdata;
    logic        s_rdv;

    sysid_regs_mm #(.DATA_W(8), .CNT_W(16), .READ_LATENCY(1)) u_small (
        .clock(clk), .reset_n(s_rst_n), .address(s_addr), .read(s_read),
        .write(s_write), .writedata(s_wdata), .readdata(s_rdata), .readdatavalid(s_rdv)
    );

    // Latency-4 instance for reset-during-read
    logic        f_rst_n = 1'b0;
    logic        f_read  = 1'b0;
    logic        f_write = 1'b0;
    logic [2:0]  f_addr  = 3'd0;
    logic [31:0] f_wdata = '0;
    logic [31:0] f_rdata;
    logic        f_rdv;

    sysid_regs_mm #(.READ_LATENCY(4)) u_lat4 (
        .clock(clk), .reset_n(f_rst_n), .address(f_addr), .read(f_read),
        .write(f_write), .writedata(f_wdata), .readdata(f_rdata), .readdatavalid(f_rdv)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    // Scoreboard for the latency-2 instance
    typedef struct {
        logic [31:0] data;
        int          due;
        int          tag;
    } sb_t;

    sb_t         sb_q[$];
    logic [31:0] m_hold_exp = '0;
    bit          m_mon_en   = 1'b0;
    sb_t         m_pop;

    always @(negedge clk) begin
        if (m_mon_en) begin
            if (m_rdv) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL main_unexpected_rdv: got readdatavalid=1, required 0");
                end else begin
                    m_pop = sb_q.pop_front();
                    check($sformatf("main_rdata[%0d]", m_pop.tag), 64'(m_rdata), 64'(m_pop.data));
                    check($sformatf("main_due_cycle[%0d]", m_pop.tag), 64'(cyc), 64'(m_pop.due));
                    m_hold_exp = m_pop.data;
                end
            end else if (m_rdata !== m_hold_exp) begin
                check("main_rdata_hold", 64'(m_rdata), 64'(m_hold_exp));
            end
        end
    end

    task automatic m_cycle(input bit rd, input bit wr, input logic [2:0] a,
                           input logic [31:0] wd, input logic [31:0] exp, input int tag);
        sb_t e;
        m_addr  = a;
        m_read  = rd;
        m_write = wr;
        m_wdata = wd;
        if (rd) begin
            e.data = exp;
            e.due  = cyc + 2;
            e.tag  = tag;
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        m_read  = 1'b0;
        m_write = 1'b0;
    endtask

    task automatic s_rd(input logic [2:0] a, input logic [7:0] exp, input string name);
        int edges;
        s_addr = a;
        s_read = 1'b1;
        @(posedge clk);
        #1;
        edges  = 1;
        s_read = 1'b0;
        while (!s_rdv && edges < 10) begin
            @(posedge clk);
            #1;
            edges++;
        end
        check({name, "_latency"}, 64'(edges), 64'd1);
        check(name, 64'(s_rdata), 64'(exp));
    endtask

    task automatic f_rd(input logic [2:0] a, input logic [31:0] exp, input string name);
        int edges;
        f_addr = a;
        f_read = 1'b1;
        @(posedge clk);
        #1;
        edges  = 1;
        f_read = 1'b0;
        while (!f_rdv && edges < 12) begin
            @(posedge clk);
            #1;
            edges++;
        end
        check({name, "_latency"}, 64'(edges), 64'd4);
        check(name, 64'(f_rdata), 64'(exp));
    endtask

    task automatic f_wr(input logic [2:0] a, input logic [31:0] wd);
        f_addr  = a;
        f_wdata = wd;
        f_write = 1'b1;
        @(posedge clk);
        #1;
        f_write = 1'b0;
    endtask

    typedef struct {
        bit          rd;
        bit          wr;
        logic [2:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[18];

    initial begin
        int seen;

        vecs[0]  = '{1'b1, 1'b0, ADDR_ID,        32'h0,         32'd28};
        vecs[1]  = '{1'b1, 1'b0, ADDR_TIMESTAMP, 32'h0,         32'd1718117590};
        vecs[2]  = '{1'b1, 1'b0, ADDR_VERSION,   32'h0,         32'h0001_0000};
        vecs[3]  = '{1'b0, 1'b1, ADDR_SCRATCH,   32'hDEAD_BEEF, 32'h0};
        vecs[4]  = '{1'b1, 1'b0, ADDR_SCRATCH,   32'h0,         32'hDEAD_BEEF};
        vecs[5]  = '{1'b0, 1'b1, ADDR_ID,        32'd5,         32'h0};
        vecs[6]  = '{1'b1, 1'b0, ADDR_ID,        32'h0,         32'd28};
        vecs[7]  = '{1'b0, 1'b1, ADDR_TIMESTAMP, 32'h0,         32'h0};
        vecs[8]  = '{1'b1, 1'b0, ADDR_TIMESTAMP, 32'h0,         32'd1718117590};
        vecs[9]  = '{1'b1, 1'b0, ADDR_RSVD,      32'h0,         32'h0};
        vecs[10] = '{1'b0, 1'b1, ADDR_RSVD,      32'hFFFF_FFFF, 32'h0};
        vecs[11] = '{1'b1, 1'b0, ADDR_RSVD,      32'h0,         32'h0};
        vecs[12] = '{1'b1, 1'b1, ADDR_SCRATCH,   32'd7,         32'hDEAD_BEEF};
        vecs[13] = '{1'b1, 1'b0, ADDR_SCRATCH,   32'h0,         32'hDEAD_BEEF};
        vecs[14] = '{1'b0, 1'b1, ADDR_CTRL,      32'hFFFF_FFFD, 32'h0};
        vecs[15] = '{1'b1, 1'b0, ADDR_CTRL,      32'h0,         32'h1};
        vecs[16] = '{1'b0, 1'b1, ADDR_SCRATCH,   32'h1234_5678, 32'h0};
        vecs[17] = '{1'b1, 1'b0, ADDR_SCRATCH,   32'h0,         32'h1234_5678};

        // Reset state of the latency-2 instance
        repeat (3) @(posedge clk);
        #1;
        check("main_reset_rdv", 64'(m_rdv), 64'd0);
        check("main_reset_rdata", 64'(m_rdata), 64'd0);
        m_rst_n    = 1'b1;
        m_hold_exp = '0;
        m_mon_en   = 1'b1;

        for (int i = 0; i < 18; i++) begin
            m_cycle(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp, i);
        end

        // CLR zeroes the counter; counting resumes; EN=0 freezes it
        m_cycle(1'b0, 1'b1, ADDR_CTRL, 32'h3, 32'h0, 100);
        m_cycle(1'b1, 1'b0, ADDR_UPTIME_LO, 32'h0, 32'd0, 101);
        repeat (4) m_cycle(1'b0, 1'b0, ADDR_ID, 32'h0, 32'h0, 0);
        m_cycle(1'b1, 1'b0, ADDR_UPTIME_LO, 32'h0, 32'd5, 102);
        m_cycle(1'b1, 1'b0, ADDR_CTRL, 32'h0, 32'd1, 103);
        m_cycle(1'b0, 1'b1, ADDR_CTRL, 32'h0, 32'h0, 104);
        m_cycle(1'b1, 1'b0, ADDR_UPTIME_LO, 32'h0, 32'd8, 105);
        repeat (9) m_cycle(1'b0, 1'b0, ADDR_ID, 32'h0, 32'h0, 0);
        m_cycle(1'b1, 1'b0, ADDR_UPTIME_LO, 32'h0, 32'd8, 106);
        m_cycle(1'b1, 1'b0, ADDR_CTRL, 32'h0, 32'd0, 107);
        m_cycle(1'b1, 1'b0, ADDR_UPTIME_HI_SNAP, 32'h0, 32'd0, 108);
        m_cycle(1'b0, 1'b1, ADDR_CTRL, 32'h1, 32'h0, 109);

        // Narrow instance: counter wraps its low word at 0x01FF -> 0x0200
        s_rst_n = 1'b1;
        s_rd(ADDR_UPTIME_LO, 8'h00, "small_lo_first");
        repeat (510) @(posedge clk);
        #1;
        s_rd(ADDR_UPTIME_LO, 8'hFF, "small_lo_snap");
        s_rd(ADDR_UPTIME_HI_SNAP, 8'h01, "small_hi_snap");
        s_rd(ADDR_ID, 8'h1C, "small_id_trunc");
        s_rd(ADDR_TIMESTAMP, 8'hD6, "small_ts_trunc");
        s_rd(ADDR_UPTIME_HI_SNAP, 8'h01, "small_hi_hold");

        // Latency-4 instance: reset lands while reads are in flight
        f_rst_n = 1'b1;
        @(posedge clk);
        #1;
        f_wr(ADDR_SCRATCH, 32'h55);
        f_wr(ADDR_CTRL, 32'h0);
        f_addr = ADDR_SCRATCH;
        f_read = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        f_read = 1'b0;
        check("lat4_first_rdv", 64'(f_rdv), 64'd1);
        check("lat4_first_rdata", 64'(f_rdata), 64'h55);
        f_rst_n = 1'b0;
        #1;
        check("lat4_async_rdv_clear", 64'(f_rdv), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        f_rst_n = 1'b1;
        seen = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (f_rdv) seen++;
        end
        check("lat4_no_stale_rdv", 64'(seen), 64'd0);
        check("lat4_rdata_reset", 64'(f_rdata), 64'd0);
        f_rd(ADDR_SCRATCH, 32'h0, "lat4_scratch_reset");
        f_rd(ADDR_CTRL, 32'h1, "lat4_ctrl_reset");
        f_rd(ADDR_UPTIME_HI_SNAP, 32'h0, "lat4_snap_reset");

        for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(posedge clk);
        #1;
        check("main_queue_drained", 64'(sb_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sysid_regs_mm.md
# sysid_regs_mm

Parametrised Avalon-MM system-identification slave: read-only system ID, build timestamp and version words, plus a scratch register and a free-running uptime counter with coherent wide-read snapshot. It sits on the control interconnect beside the CPU, so software can confirm the hardware build and measure elapsed cycles. Read data returns with a fixed, parametrised latency, flagged by `readdatavalid`.

## Interface
- `SYSTEM_ID`, 28: value returned at ID word.
- `TIMESTAMP`, 1718117590: build timestamp word.
- `VERSION`, 32'h0001_0000: major[31:16]/minor[15:0] version word.
- `DATA_W`, 32: bus data width.
- `CNT_W`, 64: uptime counter width; legal range DATA_W < CNT_W <= 2*DATA_W.
- `READ_LATENCY`, 1: cycles from accepted read to `readdatavalid`; legal 1..4.
- `clock` in 1: sole clock, all logic on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `address` in 3: word address.
- `read` in 1: read strobe, one transfer per cycle.
- `write` in 1: write strobe.
- `writedata` in DATA_W: write data.
- `readdata` out DATA_W: read data, valid only with `readdatavalid`.
- `readdatavalid` out 1: read response strobe.

## Operation
- Register map (word address):
  - 0 ID (RO).
  - 1 TIMESTAMP (RO).
  - 2 VERSION (RO).
  - 3 SCRATCH (RW).
  - 4 UPTIME_LO (RO): counter[DATA_W-1:0].
  - 5 UPTIME_HI_SNAP (RO): high part latched by the last UPTIME_LO read.
  - 6 CTRL (RW): bit0 EN, bit1 CLR (write-1, self-clearing, reads 0); other bits read 0.
  - 7 reserved: reads 0.
- RO widths: ID, TIMESTAMP and VERSION are truncated or zero-extended to DATA_W.
- RO writes: writes to RO or reserved addresses are ignored.
- Uptime counter:
  - Increments by 1 every cycle while EN=1; wraps from all-ones to 0.
  - CLR=1 zeroes it on the next edge. CLR has priority over increment, whatever the EN value.
- Snapshot: a read of address 4 returns counter[DATA_W-1:0] and, on the same edge, loads UPTIME_HI_SNAP with counter[CNT_W-1:DATA_W] zero-extended. Low and high words are therefore from the same cycle.
- Same-cycle read and write: the read is serviced and the write is dropped.
- Read pipeline:
  - Data is captured on the edge where `read`=1.
  - It is then delayed READ_LATENCY-1 further stages.
  - Back-to-back reads are accepted every cycle, with no stall (no `waitrequest`).
- Reset values:
  - `readdata`=0, `readdatavalid`=0.
  - SCRATCH=0, EN=1, counter=0, UPTIME_HI_SNAP=0.
  - Pipeline valid bits cleared.

## Timing
- Read at cycle N → `readdatavalid`=1 and `readdata` at cycle N+READ_LATENCY, for exactly one cycle per read.
- `readdata` holds its last value while `readdatavalid`=0.
- Write at cycle N → register updated at edge ending N; a read at N+1 sees the new value.
- CTRL.EN write: takes effect from the next cycle.
- Counter values seen by software:
  - Two reads of UPTIME_LO k cycles apart, with EN=1 throughout, differ by k (mod 2^DATA_W).
  - A read at cycle 0 after reset release returns 0.
- Reset asserted mid-read: in-flight responses are discarded, and `readdatavalid` deasserts asynchronously.

## Structure
- Package `sysid_pkg`:
  - Address constants ADDR_ID … ADDR_CTRL.
  - CTRL bit indices.
  - Default VERSION.
- One sub-module, `sysid_rd_pipe`: a parametrised valid/data delay line, depth READ_LATENCY-1 (pass-through when 0), async active-low reset.
- Top holds: the register file, counter, snapshot, and the address decode mux.

## Test plan
- Reset, READ_LATENCY=2: read addr 0,1,2 on consecutive cycles → responses at cycles +2,+3,+4 of 28, 1718117590, 32'h0001_0000, one valid pulse each.
- Write 32'hDEAD_BEEF to addr 3, then read addr 3 → DEAD_BEEF. Write addr 0 with 5, then read addr 0 → still 28.
- CNT_W=64, force counter to 64'h0000_0001_FFFF_FFFF. Read addr 4 → FFFF_FFFF; next cycle read addr 5 → 1, not 2.
- Write CTRL=3 (EN+CLR) → counter 0 next cycle, then counting. CTRL read → 1. Write CTRL=0 → two LO reads 10 cycles apart are equal.
- Assert `read` and `write` together at addr 3 with writedata 7 → old SCRATCH returned, SCRATCH unchanged.
- Assert reset_n=0 between read acceptance and response with READ_LATENCY=4 → no `readdatavalid` after release; all registers at reset values.
